mesh_result_collector: RTL
==========================

Name: mesh_result_collector

Overview:
- Downstream consumer of the 26x18 toroidal two-bit comparator mesh.
- Watches the mesh's 468-bit per-node output vector until it holds unchanged for a set number of cycles (convergence) or a cycle budget expires.
- Then freezes a snapshot and streams it out row by row (26 bits per beat) over a valid/ready handshake, accumulating the population count.
- Reports converged/timeout status, cycles used and the total count of asserted nodes.

Parameters:
- COLS, 26, nodes per row (column index = node index mod COLS)
- ROWS, 18, number of rows
- STABLE_CYCLES, 4, consecutive unchanged comparisons required to declare convergence (>=1)
- MAX_CYCLES, 1000, monitor-cycle budget before timeout (>=2, must fit CYC_W)
- CYC_W, 16, width of the cycle counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin monitoring; sampled only in IDLE
- node_out  in  468  mesh per-node outputs; bit j = node j, row j/26, column j%26
- busy  out  1  high in MONITOR and STREAM
- done  out  1  one-cycle pulse after the last row is accepted
- converged  out  1  1 = stopped on stability, 0 = stopped on timeout; valid from STREAM entry until next start
- cycles_used  out  CYC_W  MONITOR cycles elapsed; valid from STREAM entry until next start
- ones_count  out  9  popcount of the frozen snapshot; final when done pulses, held until next start
- row_data  out  26  snapshot bits [row_idx*26 +: 26]
- row_idx  out  5  current row, 0..17
- row_valid  out  1  row_data valid
- row_ready  in  1  consumer accepts the row

Behaviour:
- Reset (async assert, sync deassert): state IDLE; busy, done, converged, row_valid = 0; cycles_used, ones_count, row_idx, row_data, snapshot, stable counter = 0. Reset asserted mid-operation aborts immediately; no done pulse.
- States: IDLE, MONITOR, STREAM, DONE.
- IDLE: start=1 at edge k clears converged, cycles_used, ones_count, stable counter and first-sample flag, and enters MONITOR at k+1. A start in any other state is ignored.
- MONITOR, every edge:
  - snap <= node_out.
  - cycles_used increments.
  - eq = (node_out == snap) and not first cycle. The first MONITOR cycle never counts as equal.
  - eq=1: stable_cnt increments. eq=0: stable_cnt clears to 0.
- Convergence: eq=1 with stable_cnt == STABLE_CYCLES-1. Set converged=1 and go to STREAM.
- Timeout: cycles_used reaching MAX_CYCLES (counted including this edge) without convergence. Set converged=0 and go to STREAM.
- If both occur on the same edge, convergence wins: converged=1.
- The snapshot frozen on the exit edge is what gets streamed. node_out is ignored from then on.
- STREAM:
  - Entry: row_idx=0, row_valid=1.
  - On row_valid & row_ready: ones_count += popcount(row_data), row_idx increments.
  - On acceptance of row 17: row_valid drops, go to DONE.
  - With row_ready low, row_data and row_idx hold stable; no combinational ready->valid path.
  - Back-to-back acceptance gives one row per cycle, so the minimum stream is 18 cycles.
- DONE: done=1 for exactly one cycle, then IDLE. Status outputs hold.
- Widths: ones_count 9 bits, max 468, never overflows. cycles_used saturates at MAX_CYCLES.
- Popcount is per row (26 bits), never the full 468-bit vector, to bound logic depth.

Test Plan:
- Constant node_out=0, STABLE_CYCLES=4, start pulse -> converged=1, cycles_used=5, rows 0..17 stream with row_ready held high, done one cycle after row 17, ones_count=0.
- node_out toggles all-0/all-1 every cycle, MAX_CYCLES=1000 -> converged=0, cycles_used=1000. Last sample is all-1 (1000th sample) -> ones_count=468.
- Constant pattern with bit j = (j%26==0) -> every row_data = 26'h0000001, ones_count=18, row_idx sequence 0..17.
- row_ready random at 30% duty -> row_data/row_idx stable while stalled, exactly 18 acceptances, done after the 18th, ones_count matches the reference popcount.
- Stability reached exactly on cycle MAX_CYCLES (pattern changes until cycle MAX_CYCLES-STABLE_CYCLES, then constant) -> converged=1.
- rst_n asserted during STREAM at row 7 -> all outputs 0 immediately, no done. start in STREAM -> no effect.

Source files
------------

// File: rtl/mesh_result_collector.sv
// rtl/mesh_result_collector.sv - convergence monitor and row streamer for the comparator mesh
//
// Watches the mesh's per-node output vector until it holds still for
// STABLE_CYCLES comparisons or MAX_CYCLES monitor cycles elapse. It then
// streams the frozen snapshot out one row per beat and accumulates the
// population count.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin monitoring (sampled only in IDLE)
//   node_out              mesh outputs, bit j = row j/COLS, column j%COLS
//   busy, done            activity flag, one-cycle completion pulse
//   converged             1 = stopped on stability, 0 = stopped on timeout
//   cycles_used           monitor cycles elapsed
//   ones_count            popcount of the frozen snapshot
//   row_data, row_idx     current snapshot row and its index
//   row_valid, row_ready  row stream handshake

module mesh_result_collector #(
   parameter int COLS          = 26,
   parameter int ROWS          = 18,
   parameter int STABLE_CYCLES = 4,
   parameter int MAX_CYCLES    = 1000,
   parameter int CYC_W         = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [COLS*ROWS-1:0] node_out,
   output logic                 busy,
   output logic                 done,
   output logic                 converged,
   output logic [CYC_W-1:0]     cycles_used,
   output logic [8:0]           ones_count,
   output logic [COLS-1:0]      row_data,
   output logic [4:0]           row_idx,
   output logic                 row_valid,
   input  logic                 row_ready
);

   typedef enum logic [1:0] {S_IDLE, S_MONITOR, S_STREAM, S_DONE} state_t;

   localparam int               SC_W        = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [SC_W-1:0]  STABLE_LAST = SC_W'(STABLE_CYCLES - 1);
   localparam logic [CYC_W-1:0] MAX_C       = CYC_W'(MAX_CYCLES);
   localparam logic [4:0]       LAST_ROW    = 5'(ROWS - 1);

   state_t                      state_q, state_d;
   logic [ROWS-1:0][COLS-1:0]   snap_q, snap_d;
   logic [SC_W-1:0]             stable_q, stable_d;
   logic                        first_q, first_d;
   logic [CYC_W-1:0]            cycles_q, cycles_d;
   logic                        converged_q, converged_d;
   logic [8:0]                  ones_q, ones_d;
   logic [4:0]                  row_idx_q, row_idx_d;

   logic                        eq;
   logic [CYC_W-1:0]            cyc_inc;
   logic [COLS-1:0]             row_sel;

   // Popcount one row at a time so the adder tree stays COLS bits deep.
   function automatic logic [8:0] row_popcount(input logic [COLS-1:0] v);
      logic [8:0] cnt;
      cnt = '0;
      for (int i = 0; i < COLS; i++) begin
         cnt = cnt + 9'(v[i]);
      end
      return cnt;
   endfunction

   assign row_sel = snap_q[row_idx_q];

   always_comb begin
      state_d     = state_q;
      snap_d      = snap_q;
      stable_d    = stable_q;
      first_d     = first_q;
      cycles_d    = cycles_q;
      converged_d = converged_q;
      ones_d      = ones_q;
      row_idx_d   = row_idx_q;
      // The first monitor sample has nothing valid to compare against.
      eq          = !first_q && (node_out == snap_q);
      cyc_inc     = cycles_q + CYC_W'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_MONITOR;
               converged_d = 1'b0;
               cycles_d    = '0;
               ones_d      = '0;
               stable_d    = '0;
               first_d     = 1'b1;
               row_idx_d   = '0;
            end
         end
         S_MONITOR: begin
            snap_d   = node_out;
            cycles_d = cyc_inc;
            first_d  = 1'b0;
            stable_d = eq ? stable_q + SC_W'(1) : '0;
            // Convergence is tested first so it wins a tie with the budget.
            if (eq && (stable_q == STABLE_LAST)) begin
               converged_d = 1'b1;
               state_d     = S_STREAM;
               row_idx_d   = '0;
            end else if (cyc_inc == MAX_C) begin
               converged_d = 1'b0;
               state_d     = S_STREAM;
               row_idx_d   = '0;
            end
         end
         S_STREAM: begin
            if (row_ready) begin
               ones_d = ones_q + row_popcount(row_sel);
               // row_idx parks on the last row so it never leaves 0..ROWS-1.
               if (row_idx_q == LAST_ROW) begin
                  state_d = S_DONE;
               end else begin
                  row_idx_d = row_idx_q + 5'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         snap_q      <= '0;
         stable_q    <= '0;
         first_q     <= 1'b0;
         cycles_q    <= '0;
         converged_q <= 1'b0;
         ones_q      <= '0;
         row_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         snap_q      <= snap_d;
         stable_q    <= stable_d;
         first_q     <= first_d;
         cycles_q    <= cycles_d;
         converged_q <= converged_d;
         ones_q      <= ones_d;
         row_idx_q   <= row_idx_d;
      end
   end

   assign busy        = (state_q == S_MONITOR) || (state_q == S_STREAM);
   assign done        = (state_q == S_DONE);
   assign row_valid   = (state_q == S_STREAM);
   assign converged   = converged_q;
   assign cycles_used = cycles_q;
   assign ones_count  = ones_q;
   assign row_idx     = row_idx_q;
   assign row_data    = row_sel;

endmodule
